factor_search: RTL and testbench

- Sequential trial-division factoriser. It is the constructive counterpart to the factor-pair cover checks in our formal labs: given N, it produces the pair rather than checking a supplied x*y == N.
- Accepts N over a valid/ready input, tests divisors 2, 3, 5, 7, ... in order, and returns the smallest-factor pair, or a PRIME, DEGENERATE or TIMEOUT status, over a valid/ready output.
- Serves as both a lab DUT and a reference model for the factor cover properties.

---
 rtl/factor_pkg.sv | 20 ++
 rtl/seq_divider.sv | 80 ++++++++
 rtl/factor_search.sv | 152 +++++++++++++++
 tb/tb_factor_search.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/factor_pkg.sv
// Shared types for the trial-division factoriser: FSM states, result status codes, default width.
package factor_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ST_COMPOSITE  = 2'd0,
        ST_PRIME      = 2'd1,
        ST_DEGENERATE = 2'd2,
        ST_TIMEOUT    = 2'd3
    } status_e;

endpackage

// File: rtl/seq_divider.sv
// Fixed-latency restoring divider: the first quotient bit is produced on the start edge,
// so done pulses in the WIDTH-th cycle after start and results are valid alongside it.
module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] src_rem, src_quo, src_div;
    logic [WIDTH:0]   shifted;
    logic             step;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        step    = start || busy_q;
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_div = start ? divisor : div_q;
        shifted = {src_rem, src_quo[WIDTH-1]};
        if (step) begin
            div_d = src_div;
            // Partial remainder is always < divisor, so the difference fits in WIDTH bits.
            if (shifted >= {1'b0, src_div}) begin
                rem_d = shifted[WIDTH-1:0] - src_div;
                quo_d = {src_quo[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {src_quo[WIDTH-2:0], 1'b0};
            end
            cnt_d  = start ? CW'(1) : cnt_q + CW'(1);
            done_d = (cnt_d == CW'(WIDTH));
            busy_d = !done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/factor_search.sv
// Sequential trial-division factoriser returning the least-prime-factor pair of N.
// Define FACTOR_SEARCH_FORMAL_EN to embed the result/handshake assertions and status covers.
module factor_search
    import factor_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_status,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y
);
    state_e           state_q, state_d;
    status_e          status_q, status_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;

    logic             div_start, div_busy, div_done;
    logic [WIDTH-1:0] div_quo, div_rem;
    logic [2*WIDTH-1:0] d_sq;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (n_q),
        .divisor   (d_q),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Full double-width square: no overflow even for d near 2^WIDTH.
    assign d_sq = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        n_d       = n_q;
        d_d       = d_q;
        count_d   = count_q;
        x_d       = x_q;
        y_d       = y_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_d     = in_n;
                    d_d     = WIDTH'(2);
                    count_d = '0;
                    if (in_n < WIDTH'(2)) begin
                        state_d  = DONE;
                        status_d = ST_DEGENERATE;
                        x_d      = WIDTH'(1);
                        y_d      = in_n;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (d_sq > {{WIDTH{1'b0}}, n_q}) begin
                    state_d  = DONE;
                    status_d = ST_PRIME;
                    x_d      = WIDTH'(1);
                    y_d      = n_q;
                end else if (TIMEOUT != 0 && count_q == WIDTH'(TIMEOUT)) begin
                    state_d  = DONE;
                    status_d = ST_TIMEOUT;
                    x_d      = '0;
                    y_d      = '0;
                end else if (!div_busy) begin
                    div_start = 1'b1;
                    state_d   = DIVIDE;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    count_d = count_q + WIDTH'(1);
                    if (div_rem == '0) begin
                        state_d  = DONE;
                        status_d = ST_COMPOSITE;
                        x_d      = d_q;
                        y_d      = div_quo;
                    end else begin
                        state_d = CHECK;
                        d_d     = (d_q == WIDTH'(2)) ? WIDTH'(3) : d_q + WIDTH'(2);
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            status_q <= ST_COMPOSITE;
            n_q      <= '0;
            d_q      <= WIDTH'(2);
            count_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            n_q      <= n_d;
            d_q      <= d_d;
            count_q  <= count_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_status = status_q;
    assign out_x      = x_q;
    assign out_y      = y_q;

`ifdef FACTOR_SEARCH_FORMAL_EN
    a_composite: assert property (@(posedge clk) disable iff (rst)
        (out_valid && out_status == ST_COMPOSITE) |->
            (out_x > WIDTH'(1) && out_y > WIDTH'(1) &&
             ({{WIDTH{1'b0}}, out_x} * {{WIDTH{1'b0}}, out_y}) == {{WIDTH{1'b0}}, n_q}));
    a_prime: assert property (@(posedge clk) disable iff (rst)
        (out_valid && out_status == ST_PRIME) |-> (out_x == WIDTH'(1) && out_y == n_q));
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_status) && $stable(out_x) && $stable(out_y)));
    a_excl: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));
    c_composite: cover property (@(posedge clk) disable iff (rst) out_valid && out_status == ST_COMPOSITE);
    c_prime:     cover property (@(posedge clk) disable iff (rst) out_valid && out_status == ST_PRIME);
    c_degen:     cover property (@(posedge clk) disable iff (rst) out_valid && out_status == ST_DEGENERATE);
    c_timeout:   cover property (@(posedge clk) disable iff (rst) out_valid && out_status == ST_TIMEOUT);
`endif

endmodule

// File: tb/tb_factor_search.sv
// Directed table-driven bench: unlimited-search DUT (u=0) and TIMEOUT=4 DUT (u=1).
module tb_factor_search;
    logic        clk;
    logic        rst;
    logic [1:0]  in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_n;
    logic [1:0]  out_status [2];
    logic [63:0] out_x [2];
    logic [63:0] out_y [2];

    int checks   = 0;
    int failures = 0;

    factor_search #(.WIDTH(64), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_n(in_n),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_status(out_status[0]),
        .out_x(out_x[0]), .out_y(out_y[0]));

    factor_search #(.WIDTH(64), .TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_n(in_n),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_status(out_status[1]),
        .out_x(out_x[1]), .out_y(out_y[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          u;
        logic [63:0] n;
        logic [1:0]  st;
        logic [63:0] x;
        logic [63:0] y;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int u, input logic [63:0] n, input logic [1:0] st,
                       input logic [63:0] x, input logic [63:0] y, input int lat);
        vec_t v;
        v.u = u; v.n = n; v.st = st; v.x = x; v.y = y; v.lat = lat;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Present N, then count cycles from the accepting edge (cycle 1) until out_valid is seen.
    task automatic run_vec(input int u, input logic [63:0] n, output logic [1:0] st,
                           output logic [63:0] x, output logic [63:0] y, output int lat);
        int guard;
        guard = 0;
        while (!in_ready[u] && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        in_n = n;
        in_valid[u] = 1'b1;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        lat = 1;
        while (!out_valid[u] && lat < 5000) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid[u]) lat = -1;
        st = out_status[u];
        x  = out_x[u];
        y  = out_y[u];
    endtask

    initial begin
        logic [1:0]  st;
        logic [63:0] x, y;
        int          lat;

        rst = 1'b0; in_valid = '0; out_ready = 2'b11; in_n = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", 0, 64'(in_ready), 64'd3);
        chk("rst_out_valid", 0, 64'(out_valid), 64'd0);
        chk("rst_status", 0, 64'(out_status[0]), 64'd0);
        chk("rst_x", 0, out_x[0], 64'd0);
        chk("rst_y", 0, out_y[0], 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        add(0, 64'd15,          2'd0, 64'd3, 64'd5,          131);
        add(0, 64'd8191,        2'd1, 64'd1, 64'd8191,       2927);
        add(0, 64'd2147483648,  2'd0, 64'd2, 64'd1073741824, 66);
        add(0, 64'd0,           2'd2, 64'd1, 64'd0,          1);
        add(0, 64'd1,           2'd2, 64'd1, 64'd1,          1);
        add(0, 64'd2,           2'd1, 64'd1, 64'd2,          2);
        add(0, 64'd4,           2'd0, 64'd2, 64'd2,          66);
        add(0, 64'd9,           2'd0, 64'd3, 64'd3,          131);
        add(1, 64'd400000009,   2'd3, 64'd0, 64'd0,          262);
        add(1, 64'd15,          2'd0, 64'd3, 64'd5,          131);
        add(1, 64'd2,           2'd1, 64'd1, 64'd2,          2);

        foreach (tbl[i]) begin
            run_vec(tbl[i].u, tbl[i].n, st, x, y, lat);
            chk("status", i, 64'(st), 64'(tbl[i].st));
            chk("x", i, x, tbl[i].x);
            chk("y", i, y, tbl[i].y);
            chk("latency", i, 64'(lat), 64'(tbl[i].lat));
            @(posedge clk); #1;
            chk("post_hs_in_ready", i, 64'(in_ready[tbl[i].u]), 64'd1);
            chk("post_hs_out_valid", i, 64'(out_valid[tbl[i].u]), 64'd0);
        end

        // Backpressure: hold out_ready low, and try to sneak in another N while DONE.
        out_ready[0] = 1'b0;
        run_vec(0, 64'd15, st, x, y, lat);
        chk("bp_latency", 0, 64'(lat), 64'd131);
        in_n = 64'd99;
        in_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", c, 64'(out_valid[0]), 64'd1);
            chk("bp_in_ready", c, 64'(in_ready[0]), 64'd0);
            chk("bp_xy", c, {out_x[0][31:0], out_y[0][31:0]}, {32'd3, 32'd5});
            chk("bp_status", c, 64'(out_status[0]), 64'd0);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 0, 64'(in_ready[0]), 64'd1);
        chk("bp_release_out_valid", 0, 64'(out_valid[0]), 64'd0);

        // Reset in the middle of a division.
        in_n = 64'd15;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 0, 64'(out_valid[0]), 64'd0);
        chk("midrst_in_ready", 0, 64'(in_ready[0]), 64'd1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_in_ready", 0, 64'(in_ready[0]), 64'd1);
        chk("postrst_out_valid", 0, 64'(out_valid[0]), 64'd0);
        run_vec(0, 64'd21, st, x, y, lat);
        chk("postrst_status", 0, 64'(st), 64'd0);
        chk("postrst_x", 0, x, 64'd3);
        chk("postrst_y", 0, y, 64'd7);
        chk("postrst_latency", 0, 64'(lat), 64'd131);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
